zero_scan_unit: RTL and testbench
=================================

// Module: zero_scan_unit
// PURPOSE
//  Multi-cycle zero detector and leading-zero counter for a WIDTH-bit operand.
//  Scans CHUNK bits per cycle from the MSB end and stops at the first non-zero chunk.
//  Returns a zero flag (Z) and a leading-zero count (LZC).
//  Sits beside the ALU; used for the branch Z flag on wide operands and for clz-style ops.
// PARAMETERS
//  WIDTH  32  operand width; must be a multiple of CHUNK
//  CHUNK  8   bits examined per cycle; 1..WIDTH; NCH = WIDTH/CHUNK chunks
//  LW     $clog2(WIDTH+1)  width of lzc (derived; do not override)
// PORTS
//  clk    in   1      single clock, rising edge
//  rst_n  in   1      synchronous, active-low reset
//  start  in   1      request; sampled only when the unit can accept it
//  data   in   WIDTH  operand; captured on the accepting edge only
//  busy   out  1      1 while in SCAN
//  done   out  1      one-cycle pulse; results are valid from this cycle on
//  zero   out  1      1 iff the captured operand == 0
//  lzc    out  LW     count of leading zeros of the captured operand; WIDTH if all zero
// BEHAVIOUR
//  Reset (rst_n==0 at a rising edge):
//   state=IDLE; busy=0; done=0; zero=0; lzc=0; internal data register and chunk index cleared.
//   An in-flight scan is abandoned. No done pulse is produced for it.
//  FSM states: IDLE, SCAN, DONE.
//   IDLE: start=1 -> latch data into dreg; idx=NCH-1; go to SCAN.
//   SCAN: each edge examines chunk c = dreg[idx*CHUNK +: CHUNK].
//    c!=0 -> zero<=0; lzc<=(NCH-1-idx)*CHUNK + clz(c); go to DONE.
//    c==0 and idx==0 -> zero<=1; lzc<=WIDTH; go to DONE.
//    otherwise -> idx<=idx-1; stay in SCAN.
//   DONE: done=1 for exactly this cycle, then go to IDLE.
//    start=1 in DONE is accepted exactly as in IDLE (back-to-back). The next state is then SCAN.
//  start is ignored while in SCAN: no queueing; data is not re-sampled.
//  busy=1 only in SCAN. done=1 only in DONE. busy and done are never high together.
//  Latency: k = number of chunks examined (1..NCH).
//   Accept edge t; done is high in the cycle after edge t+k.
//   Worst case (all zero) is NCH+1 cycles from accept to done.
//  zero/lzc hold their last result from the DONE cycle until the next result is written.
//   A new accept does not clear them.
//  clz(c): count of leading zeros within a CHUNK-bit non-zero chunk, range 0..CHUNK-1.
//   Purely combinational.
//  Arithmetic: lzc is computed at LW bits. The maximum value WIDTH fits by construction.
//  CHUNK==WIDTH degenerates to a single-chunk scan; the fixed 2-cycle accept->done latency applies.
//  data changes after the accept edge have no effect on the result.
// TESTING (WIDTH=32, CHUNK=8 unless stated)
//  1. Reset, then data=0x0000_0000 with start pulse -> busy 4 cycles, done 1 cycle; zero=1, lzc=32.
//  2. data=0x8000_0000 -> 1 chunk scanned; done in cycle after accept+1; zero=0, lzc=0.
//  3. data=0x0000_0001 -> 4 chunks scanned; zero=0, lzc=31.
//     data=0x0010_0000 -> 2 chunks scanned; lzc=11.
//  4. Back-to-back: start held high across DONE with data 0x00FF_0000, then 0x0000_0100.
//     -> Second scan starts without an IDLE cycle; lzc=8 then lzc=23.
//     start pulses during SCAN are ignored.
//  5. rst_n low mid-scan (data=0, after 2 SCAN cycles) -> next cycle busy=0, done=0, zero=0, lzc=0.
//     No done pulse follows.
//  6. CHUNK=1 and CHUNK=32 builds -> sweep random operands plus 0 and each one-hot value.
//     zero/lzc must match a reference model; latency must equal chunks examined + 1.

Source files
------------

// File: rtl/zero_scan_unit.sv
// Multi-cycle zero detect / leading-zero count, scanning CHUNK bits per cycle from the MSB end.
// Latency: k+1 cycles from accept edge to done (k = chunks examined, 1..NCH).
// Backpressure: start is taken in IDLE or DONE only; requests during SCAN are dropped.
module zero_scan_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic [LW-1:0]    lzc
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  dreg;
    logic [IW-1:0]     idx;
    logic [CHUNK-1:0]  chunk;
    logic              chunk_nz;
    logic              last_chunk;
    logic              accept;
    logic [LW-1:0]     clz_c;
    logic              found;

    assign chunk      = dreg[idx*CHUNK +: CHUNK];
    assign chunk_nz   = |chunk;
    assign last_chunk = (idx == '0);
    // DONE accepts like IDLE so back-to-back requests lose no cycle
    assign accept     = start && (state != S_SCAN);

    // Leading zeros inside the current chunk; only meaningful when the chunk is non-zero
    always_comb begin
        clz_c = '0;
        found = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (!found) begin
                if (chunk[i]) begin
                    found = 1'b1;
                end else begin
                    clz_c = clz_c + LW'(1);
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = start ? S_SCAN : S_IDLE;
            S_SCAN:  state_nxt = (chunk_nz || last_chunk) ? S_DONE : S_SCAN;
            S_DONE:  state_nxt = start ? S_SCAN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state; busy and done are mutually exclusive by construction
    always_comb begin
        busy = (state == S_SCAN);
        done = (state == S_DONE);
    end

    // Operand capture, chunk walk and result registers; results hold until the next scan finishes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dreg <= '0;
            idx  <= '0;
            zero <= 1'b0;
            lzc  <= '0;
        end else if (accept) begin
            dreg <= data;
            idx  <= IW'(NCH - 1);
        end else if (state == S_SCAN) begin
            if (chunk_nz) begin
                zero <= 1'b0;
                lzc  <= LW'((NCH - 1 - int'(idx)) * CHUNK) + clz_c;
            end else if (last_chunk) begin
                zero <= 1'b1;
                lzc  <= LW'(WIDTH);
            end else begin
                idx  <= idx - IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_zero_scan_unit.sv
// Directed-vector bench for zero_scan_unit; CHUNK=8, 1 and 32 builds run side by side on shared inputs.
// Each request waits a fixed window long enough for the slowest build, then checks results and latency.
// Hand-written sequences cover back-to-back accept, ignored start during SCAN and mid-scan reset.
module tb_zero_scan_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] data;

    logic        busy8, done8, zero8;
    logic [5:0]  lzc8;
    logic        busy1, done1, zero1;
    logic [5:0]  lzc1;
    logic        busy32, done32, zero32;
    logic [5:0]  lzc32;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic        z;
        int          l;
    } vec_t;

    vec_t vt[10];

    zero_scan_unit #(.WIDTH(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data),
        .busy(busy8), .done(done8), .zero(zero8), .lzc(lzc8)
    );

    zero_scan_unit #(.WIDTH(32), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data),
        .busy(busy1), .done(done1), .zero(zero1), .lzc(lzc1)
    );

    zero_scan_unit #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data),
        .busy(busy32), .done(done32), .zero(zero32), .lzc(lzc32)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_lzc(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return 31 - i;
        end
        return 32;
    endfunction

    // Wait for done on the CHUNK=8 build; lat = edges elapsed, -1 if it never came
    task automatic wait_done8(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] d, input logic ez, input int el, input string tag);
        int   lat8, lat1, lat32, dn8, dn1, dn32, bz8, ovl;
        int   k8, k1;
        logic rz8, rz1, rz32;
        int   rl8, rl1, rl32;
        lat8 = -1; lat1 = -1; lat32 = -1;
        dn8 = 0; dn1 = 0; dn32 = 0; bz8 = 0; ovl = 0;
        rz8 = ~ez; rz1 = ~ez; rz32 = ~ez;
        rl8 = -1; rl1 = -1; rl32 = -1;
        start = 1'b1;
        data  = d;
        @(posedge clk); #1;
        start = 1'b0;
        data  = $urandom;
        if (busy8) bz8++;
        for (int c = 1; c <= 36; c++) begin
            @(posedge clk); #1;
            if (busy8) bz8++;
            if ((busy8 && done8) || (busy1 && done1) || (busy32 && done32)) ovl++;
            if (done8) begin
                dn8++;
                if (lat8 < 0) begin lat8 = c; rz8 = zero8; rl8 = int'(lzc8); end
            end
            if (done1) begin
                dn1++;
                if (lat1 < 0) begin lat1 = c; rz1 = zero1; rl1 = int'(lzc1); end
            end
            if (done32) begin
                dn32++;
                if (lat32 < 0) begin lat32 = c; rz32 = zero32; rl32 = int'(lzc32); end
            end
        end
        k8 = ez ? 4  : (el / 8) + 1;
        k1 = ez ? 32 : el + 1;
        check($sformatf("%s c8 zero", tag),   int'(rz8), int'(ez));
        check($sformatf("%s c8 lzc", tag),    rl8, el);
        check($sformatf("%s c8 latency", tag), lat8, k8);
        check($sformatf("%s c8 busy cycles", tag), bz8, k8);
        check($sformatf("%s c8 done pulses", tag), dn8, 1);
        check($sformatf("%s c1 zero", tag),   int'(rz1), int'(ez));
        check($sformatf("%s c1 lzc", tag),    rl1, el);
        check($sformatf("%s c1 latency", tag), lat1, k1);
        check($sformatf("%s c1 done pulses", tag), dn1, 1);
        check($sformatf("%s c32 zero", tag),  int'(rz32), int'(ez));
        check($sformatf("%s c32 lzc", tag),   rl32, el);
        check($sformatf("%s c32 latency", tag), lat32, 1);
        check($sformatf("%s busy&done overlap", tag), ovl, 0);
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        int          dn;

        vt[0] = '{32'h0000_0000, 1'b1, 32};
        vt[1] = '{32'h8000_0000, 1'b0, 0};
        vt[2] = '{32'h0000_0001, 1'b0, 31};
        vt[3] = '{32'h0010_0000, 1'b0, 11};
        vt[4] = '{32'h00FF_0000, 1'b0, 8};
        vt[5] = '{32'h0000_0100, 1'b0, 23};
        vt[6] = '{32'hFFFF_FFFF, 1'b0, 0};
        vt[7] = '{32'h0000_8000, 1'b0, 16};
        vt[8] = '{32'h4000_0000, 1'b0, 1};
        vt[9] = '{32'h0000_0080, 1'b0, 24};

        rst_n = 1'b0;
        start = 1'b0;
        data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(busy8), 0);
        check("reset done", int'(done8), 0);
        check("reset zero", int'(zero8), 0);
        check("reset lzc",  int'(lzc8),  0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vt[i].d, vt[i].z, vt[i].l, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 32; i++) begin
            d = 32'h1 << i;
            run_op(d, 1'b0, ref_lzc(d), $sformatf("onehot%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            run_op(d, (d == 32'h0), ref_lzc(d), $sformatf("rand%0d", i));
        end

        // Back-to-back: start held through DONE; data changed during SCAN must not be re-sampled
        start = 1'b1;
        data  = 32'h00FF_0000;
        @(posedge clk); #1;
        data  = 32'h0000_0100;
        @(posedge clk); #1;
        check("b2b first busy", int'(busy8), 1);
        @(posedge clk); #1;
        check("b2b first done", int'(done8), 1);
        check("b2b first busy in done", int'(busy8), 0);
        check("b2b first lzc", int'(lzc8), 8);
        check("b2b first zero", int'(zero8), 0);
        @(posedge clk); #1;
        check("b2b second no idle gap", int'(busy8), 1);
        check("b2b done low after pulse", int'(done8), 0);
        check("b2b lzc held on accept", int'(lzc8), 8);
        start = 1'b0;
        wait_done8(lat);
        check("b2b second latency", lat, 3);
        check("b2b second lzc", int'(lzc8), 23);
        check("b2b second zero", int'(zero8), 0);
        repeat (40) @(posedge clk);
        #1;

        // start pulse during SCAN is dropped
        start = 1'b1;
        data  = 32'h0000_0001;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        data  = 32'h8000_0000;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done8(lat);
        check("scan-start latency", lat, 2);
        check("scan-start lzc", int'(lzc8), 31);
        @(posedge clk); #1;
        check("scan-start no queued busy", int'(busy8), 0);
        check("scan-start no second done", int'(done8), 0);
        repeat (40) @(posedge clk);
        #1;

        // Reset in the middle of an all-zero scan
        start = 1'b1;
        data  = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst still scanning", int'(busy8), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst busy", int'(busy8), 0);
        check("midrst done", int'(done8), 0);
        check("midrst zero", int'(zero8), 0);
        check("midrst lzc",  int'(lzc8),  0);
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done8) dn++;
        end
        check("midrst no done after", dn, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
